uart_tx_sched: RTL
==================

# uart_tx_sched

Round-robin scheduler that shares a single `uart_tx` byte transmitter among `NUM_REQ` independent requesters. Each requester offers a byte over a valid/ready handshake. The scheduler picks one requester at a time and produces a clean `uart_en` rising edge with stable `uart_din`. It then tracks `uart_tx_busy` through the frame and enforces an idle gap so the transmitter's edge detector re-arms. It sits directly between the message/command sources and the `uart_tx` instance.

## Interface
- `NUM_REQ`, default 4: number of requesters; legal range 2..16.
- `BUSY_TIMEOUT`, default 16: maximum cycles in LAUNCH waiting for `uart_tx_busy`; legal range ≥4.
- `GAP_CYCLES`, default 2: cycles `uart_en` is held low after a frame before the next grant; legal range ≥2.
- `ID_W`: localparam, equal to `$clog2(NUM_REQ)`.

Ports:
- `sys_clk` — input, 1 bit: clock.
- `sys_rst_n` — input, 1 bit: reset, asynchronous, active-low.
- `req_valid` — input, `NUM_REQ` bits: per-requester byte available.
- `req_data` — input, `8*NUM_REQ` bits: requester i's byte is `req_data[8*i+7:8*i]`.
- `req_mask` — input, `NUM_REQ` bits: 1 = requester enabled.
- `req_ready` — output, `NUM_REQ` bits: one-hot or zero; transfer occurs on the clock edge where `req_valid[i] & req_ready[i]`.
- `uart_en` — output, 1 bit: start request to `uart_tx`, registered.
- `uart_din` — output, 8 bits: byte to `uart_tx`, registered.
- `uart_tx_busy` — input, 1 bit: `uart_tx` busy flag.
- `grant_id` — output, `ID_W` bits: index of the last accepted requester.
- `tx_active` — output, 1 bit: high when the FSM is not in IDLE.
- `timeout_err` — output, 1 bit: sticky; set when busy never rose.
- `clr_err` — input, 1 bit: clears `timeout_err`.

## Operation
- **Reset values:** state IDLE; `uart_en`=0; `uart_din`=0; `grant_id`=0; `timeout_err`=0; `tx_active`=0; `req_ready`=0; `last_grant`=`NUM_REQ-1`, so requester 0 has first priority.
- **States:** IDLE, LAUNCH, WAIT_DONE, GAP.
- **IDLE**
  - `req_ready` is combinational.
  - It is high only for the round-robin winner among `req_valid & req_mask`, searching from `last_grant+1` upward and wrapping modulo `NUM_REQ`.
  - It is forced to 0 while `uart_tx_busy`=1 or while in reset.
  - On a transfer: `uart_din`←byte, `grant_id`←i, `last_grant`←i, `uart_en`←1, timeout counter cleared, next state LAUNCH.
- **LAUNCH**
  - `uart_en` and `uart_din` are held.
  - If `uart_tx_busy`=1: `uart_en`←0, next state WAIT_DONE.
  - Otherwise, when the counter reaches `BUSY_TIMEOUT-1`: `timeout_err`←1, `uart_en`←0, the byte is dropped, next state GAP.
- **WAIT_DONE:** `uart_en`=0; when `uart_tx_busy`=0, next state GAP with the gap counter cleared.
- **GAP:** after `GAP_CYCLES` cycles, next state IDLE.
- **Fairness:** the requester just served has lowest priority on the next grant. A requester that stays valid is served at most once per `NUM_REQ` grants while others are valid.
- **Masking:**
  - A masked requester never sees ready; its valid is ignored.
  - A mask change takes effect at the next IDLE evaluation.
  - A mask change does not abort an in-flight frame.
- **Error flag:** `clr_err` clears `timeout_err`; if set and clear occur in the same cycle, set wins.
- **Requester obligation:** hold `req_valid` and data stable until the transfer. Dropping `req_valid` before ready is legal and withdraws the request.
- **Reset mid-frame:** outputs return to reset values immediately (asynchronous). No pending transfer is retained. After reset the scheduler waits in IDLE until `uart_tx_busy`=0 before granting.

## Timing
- **Transfer to start:** transfer at edge T gives `uart_en`=1 and `uart_din` valid from T.
- **Expected busy latency:** with the team `uart_tx` (2-flop edge detect), busy becomes high 2 cycles after `uart_en`. LAUNCH exits at T+3, so `uart_en` is high for 3 cycles.
- **`uart_din` stability:** stable from T until the next transfer.
- **Grant spacing:** minimum spacing between transfers is 3 + busy duration + `GAP_CYCLES` + 1 cycles.
- **`uart_en` low time:** `uart_en` is low at least `GAP_CYCLES`+1 cycles between frames.
- **Zero-latency grant:** with a valid request in IDLE, ready is asserted in the same cycle; there is no wait cycle.

## Test plan
Bench: DUT plus real `uart_tx` (`CLK_FREQ`=160, `UART_BPS`=10, so `BPS_CNT`=16) and a serial monitor.

- **Single requester:** reset, then `req_valid[2]`=1, data 0xA5 → `req_ready[2]` pulses once, `uart_en` high 3 cycles, monitor decodes 0xA5, `grant_id`=2, `tx_active` falls after busy+`GAP_CYCLES`.
- **All four valid:** all valid continuously, data 0x10/0x21/0x32/0x43 → serial order 0x10, 0x21, 0x32, 0x43, 0x10…; no requester served twice before the others.
- **Masking:** `req_mask`=4'b1010 with all valid → only requesters 1 and 3 are granted, alternating; 0 and 2 never see ready.
- **Timeout:** busy tied low, one request → `uart_en` high exactly `BUSY_TIMEOUT` cycles, `timeout_err`=1, then IDLE after the gap. `clr_err` pulse clears the flag; `clr_err` coincident with a new timeout leaves it 1.
- **Reset mid-frame:** assert `sys_rst_n`=0 mid-frame → `uart_en`=0 and all outputs at reset values immediately. After release, no ready while busy is still high; granting resumes once busy falls, starting with requester 0.
- **Withdrawn request:** `req_valid[1]` dropped before ready while requester 0 is being served → no transfer is recorded for requester 1.

Source files
------------

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tx byte transmitter among NUM_REQ requesters.
// Grants from IDLE only, holds uart_en until busy rises, follows the frame, then enforces an idle gap.
module uart_tx_sched #(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 16,
  parameter int GAP_CYCLES   = 2,
  localparam int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_mask,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 uart_en,
  output logic [7:0]           uart_din,
  input  logic                 uart_tx_busy,
  output logic [ID_W-1:0]      grant_id,
  output logic                 tx_active,
  output logic                 timeout_err,
  input  logic                 clr_err
);

  localparam int CNT_MAX = (BUSY_TIMEOUT > GAP_CYCLES) ? BUSY_TIMEOUT : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT_DONE, S_GAP} state_t;

  state_t             state;
  logic [ID_W-1:0]    last_grant;
  logic [CNT_W-1:0]   cnt;
  logic [NUM_REQ-1:0] cand;
  logic [NUM_REQ-1:0] upper_mask;
  logic [NUM_REQ-1:0] pool;
  logic [ID_W-1:0]    pick_id;
  logic [7:0]         pick_data;
  logic               grant_ok;

  assign cand = req_valid & req_mask;

  // Requesters above last_grant take precedence; if none are pending, wrap to the lowest index.
  always_comb begin
    upper_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      upper_mask[i] = (i > int'(last_grant));
    end
  end

  assign pool = (|(cand & upper_mask)) ? (cand & upper_mask) : cand;

  always_comb begin
    pick_id = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (pool[i]) pick_id = i[ID_W-1:0];
    end
  end

  assign pick_data = req_data[{pick_id, 3'b000} +: 8];

  // Handshake: req_ready is combinational and at most one-hot; a byte moves on the clock edge
  // where req_valid[i] & req_ready[i]. Requesters may withdraw valid at any time before that edge.
  assign grant_ok = (state == S_IDLE) && !uart_tx_busy && sys_rst_n && (|pool);

  always_comb begin
    req_ready = '0;
    if (grant_ok) req_ready[pick_id] = 1'b1;
  end

  assign tx_active = (state != S_IDLE);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= S_IDLE;
      uart_en     <= 1'b0;
      uart_din    <= '0;
      grant_id    <= '0;
      last_grant  <= ID_W'(NUM_REQ - 1);
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      // A timeout set below overrides this clear in the same cycle.
      if (clr_err) timeout_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_ok) begin
            uart_din   <= pick_data;
            grant_id   <= pick_id;
            last_grant <= pick_id;
            uart_en    <= 1'b1;
            cnt        <= '0;
            state      <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          if (uart_tx_busy) begin
            uart_en <= 1'b0;
            state   <= S_WAIT_DONE;
          end else if (cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            uart_en     <= 1'b0;
            cnt         <= '0;
            state       <= S_GAP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_WAIT_DONE: begin
          if (!uart_tx_busy) begin
            cnt   <= '0;
            state <= S_GAP;
          end
        end
        S_GAP: begin
          if (cnt == CNT_W'(GAP_CYCLES - 1)) state <= S_IDLE;
          else cnt <= cnt + CNT_W'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
